reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised register file with two asynchronous read ports, one synchronous write port and a per-register busy scoreboard.
- Replaces the negedge-written register-file register with a single-edge (posedge) design.
- Same-cycle read-after-write is handled by an internal write-through bypass.
- The scoreboard tracks registers with a pending producer so pipeline control can stall on hazards.

Parameters:
WORD_LENGTH, 8, data width in bits
ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH registers
RESET_VALUE, 0, value loaded into every register on reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
rd_addr_a  input  ADDR_WIDTH  read port A address
rd_data_a  output  WORD_LENGTH  read port A data (combinational)
busy_a  output  1  register at rd_addr_a has a pending producer
rd_addr_b  input  ADDR_WIDTH  read port B address
rd_data_b  output  WORD_LENGTH  read port B data (combinational)
busy_b  output  1  register at rd_addr_b has a pending producer
wr_en  input  1  write enable
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  WORD_LENGTH  write data
rsv_en  input  1  reserve request: mark rsv_addr busy
rsv_addr  input  ADDR_WIDTH  register to reserve
busy_vec  output  2**ADDR_WIDTH  registered busy bits, bit i = register i

Behaviour:
- Reset:
  - rst sampled on posedge; every register is set to RESET_VALUE and busy_vec to 0.
  - rst has priority over wr_en and rsv_en.
  - While rst is high, bypass is disabled: rd_data_x shows stored contents, and busy_x = busy_vec[rd_addr_x].
- Write: when wr_en=1, mem[wr_addr] <= wr_data at posedge. Latency is one cycle to storage and zero cycles to the read ports via bypass.
- Read: rd_data_x = wr_data if (wr_en && !rst && wr_addr==rd_addr_x), else mem[rd_addr_x]. Both ports are independent and may hit the same address.
- Scoreboard, per register i at posedge:
  - set if rsv_en && rsv_addr==i;
  - else clear if wr_en && wr_addr==i;
  - else hold.
  - Reserve and write to the same address in the same cycle: the reserve wins and the bit ends at 1 (a new producer has issued); the data write still occurs.
- busy_x = busy_vec[rd_addr_x] && !(wr_en && !rst && wr_addr==rd_addr_x). A value being written this cycle is not reported busy, even if the same address is being re-reserved.
- Reserving an already-busy register: the bit stays 1; no counting, single outstanding producer per register.
- Writing a non-busy register is legal: data updates and the bit stays 0.
- Address wrap: addresses are full ADDR_WIDTH, so no out-of-range condition exists.

Optional Feature:
ZERO_REG_EN
- Defined:
  - register 0 is hardwired to zero; reads of address 0 return 0, including under bypass;
  - writes to address 0 are dropped;
  - rsv_en to address 0 is ignored; busy_vec[0] is constantly 0 and busy_x is 0 for address 0;
  - reset still loads RESET_VALUE into registers 1..N-1.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Package reg_file_pkg holds:
  - default constants RF_WORD_LENGTH=8, RF_ADDR_WIDTH=3, RF_RESET_VALUE=0;
  - a typedef struct for the write request {en, addr, data}, parametrised via package constants and used by the top level and the bench.
- Sub-module reg_file_read_port, instantiated twice, takes the storage array, busy_vec and the write request. It produces rd_data and busy with the bypass and ZERO_REG_EN masking.
- Storage and scoreboard remain in reg_file_sb.

Test Plan:
All scenarios use WORD_LENGTH=8, ADDR_WIDTH=3, RESET_VALUE=3.
1. Reset: assert rst 1 cycle, then read all 8 addresses on both ports -> every rd_data=3, busy_vec=8'h00.
2. Bypass: wr_en=1, wr_addr=5, wr_data=8'hA7, rd_addr_a=rd_addr_b=5 in the same cycle -> rd_data_a=rd_data_b=8'hA7 combinationally; with wr_en=0 next cycle, still 8'hA7.
3. Scoreboard:
   - rsv_en addr 2 -> next cycle busy_vec=8'h04, busy_a=1 for rd_addr_a=2;
   - write addr 2 with 8'h11 -> busy_a=0 in that cycle, busy_vec=8'h00 next cycle.
4. Simultaneous reserve and write on addr 4 (wr_data=8'h22) -> mem[4]=8'h22, busy_vec[4]=1 after the edge; busy_a for addr 4 reads 0 during that cycle.
5. Reset mid-operation: busy_vec=8'h3C and wr_en=1 to addr 1 with 8'hFF while rst=1 -> after the edge, mem[1]=3, busy_vec=0; rd_data shows the stored value, not 8'hFF, during the rst cycle.
6. ZERO_REG_EN defined:
   - write 8'h55 to addr 0 -> read 0; rsv addr 0 -> busy_vec[0]=0;
   - after reset, addr 0 reads 0 and addr 1 reads 3.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and the write-request type for the scoreboarded register file.
// The bench also uses these definitions.
package reg_file_pkg;

    localparam int RF_WORD_LENGTH = 8;
    localparam int RF_ADDR_WIDTH  = 3;
    localparam int RF_DEPTH       = 2 ** RF_ADDR_WIDTH;

    localparam logic [RF_WORD_LENGTH-1:0] RF_RESET_VALUE = '0;

    typedef struct packed {
        logic                      en;
        logic [RF_ADDR_WIDTH-1:0]  addr;
        logic [RF_WORD_LENGTH-1:0] data;
    } wr_req_t;

    // A write in flight is visible to a reader only outside reset.
    function automatic logic wr_hits(input wr_req_t req,
                                     input logic rst,
                                     input logic [RF_ADDR_WIDTH-1:0] addr);
        return req.en && !rst && (req.addr == addr);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, one write port, reserve port and busy bits.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int WORD_LENGTH = RF_WORD_LENGTH,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0]      rd_addr_a;
    logic [WORD_LENGTH-1:0]     rd_data_a;
    logic                       busy_a;

    logic [ADDR_WIDTH-1:0]      rd_addr_b;
    logic [WORD_LENGTH-1:0]     rd_data_b;
    logic                       busy_b;

    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [WORD_LENGTH-1:0]     wr_data;

    logic                       rsv_en;
    logic [ADDR_WIDTH-1:0]      rsv_addr;

    logic [(2**ADDR_WIDTH)-1:0] busy_vec;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wr_en, wr_addr, wr_data,
        output rsv_en, rsv_addr,
        input  rd_data_a, busy_a,
        input  rd_data_b, busy_b,
        input  busy_vec
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr, wr_data,
        input  rsv_en, rsv_addr,
        output rd_data_a, busy_a,
        output rd_data_b, busy_b,
        output busy_vec
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One asynchronous read port with write-through bypass and busy lookup.
// With ZERO_REG_EN defined, address 0 reads as zero and never reports busy.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WORD_LENGTH = RF_WORD_LENGTH,
    parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0]       busy_vec,
    input  wr_req_t                wr_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [WORD_LENGTH-1:0] rd_data,
    output logic                   busy
);

    logic bypass_hit;

    assign bypass_hit = wr_hits(wr_req, rst, rd_addr);

    // The value being written is by definition produced, so a hit masks busy.
    always_comb begin
        rd_data = bypass_hit ? wr_req.data : mem[rd_addr];
        busy    = busy_vec[rd_addr] && !bypass_hit;
`ifdef ZERO_REG_EN
        if (rd_addr == '0) begin
            rd_data = '0;
            busy    = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with posedge write, two bypassed asynchronous reads and a busy scoreboard.
// Optional ZERO_REG_EN hardwires register 0 to zero and keeps it permanently non-busy.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int                     WORD_LENGTH = RF_WORD_LENGTH,
    parameter int                     ADDR_WIDTH  = RF_ADDR_WIDTH,
    parameter logic [WORD_LENGTH-1:0] RESET_VALUE = RF_RESET_VALUE
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef ZERO_REG_EN
    localparam logic [DEPTH-1:0] KEEP_MASK = ~(DEPTH'(1));
`else
    localparam logic [DEPTH-1:0] KEEP_MASK = '1;
`endif

    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]       busy_q;
    logic [DEPTH-1:0]       busy_d;
    logic [DEPTH-1:0]       set_mask;
    logic [DEPTH-1:0]       clr_mask;
    logic                   wr_store;
    wr_req_t                wr_req;

    assign wr_req = '{en: bus.wr_en, addr: bus.wr_addr, data: bus.wr_data};

`ifdef ZERO_REG_EN
    assign wr_store = bus.wr_en && (bus.wr_addr != '0);
`else
    assign wr_store = bus.wr_en;
`endif

    // Reserve beats a same-cycle write: a new producer has issued.
    always_comb begin
        set_mask = bus.rsv_en ? (DEPTH'(1) << bus.rsv_addr) : '0;
        clr_mask = bus.wr_en  ? (DEPTH'(1) << bus.wr_addr)  : '0;
        busy_d   = ((busy_q & ~clr_mask) | set_mask) & KEEP_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: RESET_VALUE};
            busy_q <= '0;
        end else begin
            if (wr_store) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
            busy_q <= busy_d;
        end
    end

    logic [WORD_LENGTH-1:0] rd_data_a;
    logic [WORD_LENGTH-1:0] rd_data_b;
    logic                   busy_a;
    logic                   busy_b;

    reg_file_read_port #(
        .WORD_LENGTH (WORD_LENGTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_port_a (
        .rst      (rst),
        .mem      (mem),
        .busy_vec (busy_q),
        .wr_req   (wr_req),
        .rd_addr  (bus.rd_addr_a),
        .rd_data  (rd_data_a),
        .busy     (busy_a)
    );

    reg_file_read_port #(
        .WORD_LENGTH (WORD_LENGTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_port_b (
        .rst      (rst),
        .mem      (mem),
        .busy_vec (busy_q),
        .wr_req   (wr_req),
        .rd_addr  (bus.rd_addr_b),
        .rd_data  (rd_data_b),
        .busy     (busy_b)
    );

    assign bus.rd_data_a = rd_data_a;
    assign bus.rd_data_b = rd_data_b;
    assign bus.busy_a    = busy_a;
    assign bus.busy_b    = busy_b;
    assign bus.busy_vec  = busy_q;

endmodule
